// File: rtl/if_fetch_unit_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
// Fetch FSM encoding plus the reset PC and bubble instruction encoding.
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a real instruction, hold, or squash to a bubble.
// Latency 1 cycle; bubble and sync reset win over load, neither asserted means hold.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int                    PC_WIDTH   = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [PC_WIDTH-1:0]   d_pc,
  input  logic [INST_WIDTH-1:0] d_inst,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  valid
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      pc    <= '0;
      inst  <= NOP_INST;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= d_pc;
      inst  <= d_inst;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding IMEM fetch, 1-entry skid buffer, IF/ID register.
// Latency req->IF/ID 2 cycles at zero wait; stall holds PC and IF/ID and parks a landing response.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                        PC_WIDTH       = 32,
  parameter int                        INST_WIDTH     = 32,
  parameter int                        REG_ADDR_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0]       RESET_PC       = RESET_PC_DEF,
  parameter logic [INST_WIDTH-1:0]     NOP_INST       = NOP_INST_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      pc_sel,
  input  logic [PC_WIDTH-1:0]       pc_imm,
  output logic                      imem_req,
  output logic [PC_WIDTH-1:0]       imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [INST_WIDTH-1:0]     imem_rdata,
  output logic [PC_WIDTH-1:0]       IF_ID_pc,
  output logic [INST_WIDTH-1:0]     IF_ID_inst,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  output logic                      IF_ID_valid
);

  fetch_state_t          state;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   req_pc_q;
  logic                  buf_valid;
  logic [PC_WIDTH-1:0]   buf_pc;
  logic [INST_WIDTH-1:0] buf_inst;

  logic redirect;
  logic accept;
  logic resp;
  logic id_load;
  logic id_bubble;

  // A redirect under stall is ignored; decode will present it again.
  assign redirect  = pc_sel && !stall;
  assign imem_req  = !reset && (state == FETCH_ISSUE) && !stall && !buf_valid && !redirect;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;
  assign resp      = (state == FETCH_WAIT) && imem_rvalid;

  assign id_load   = !stall && !redirect && (buf_valid || resp);
  assign id_bubble = !stall && (redirect || !(buf_valid || resp));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH_ISSUE;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= NOP_INST;
    end else begin
      if (redirect) begin
        pc_q <= pc_imm;
      end else if (accept) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + PC_WIDTH'(4);
      end

      case (state)
        FETCH_ISSUE: if (accept) state <= FETCH_WAIT;
        FETCH_WAIT: begin
          if (imem_rvalid)   state <= FETCH_ISSUE;
          else if (redirect) state <= FETCH_DROP;
        end
        FETCH_DROP:  if (imem_rvalid) state <= FETCH_ISSUE;
        default:     state <= FETCH_ISSUE;
      endcase

      if (redirect) begin
        buf_valid <= 1'b0;
      end else if (resp && stall) begin
        buf_valid <= 1'b1;
        buf_pc    <= req_pc_q;
        buf_inst  <= imem_rdata;
      end else if (buf_valid && !stall) begin
        buf_valid <= 1'b0;
      end
    end
  end

  if_id_reg #(
    .PC_WIDTH  (PC_WIDTH),
    .INST_WIDTH(INST_WIDTH),
    .NOP_INST  (NOP_INST)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (id_load),
    .bubble(id_bubble),
    .d_pc  (buf_valid ? buf_pc : req_pc_q),
    .d_inst(buf_valid ? buf_inst : imem_rdata),
    .pc    (IF_ID_pc),
    .inst  (IF_ID_inst),
    .valid (IF_ID_valid)
  );

  assign IF_ID_rs1 = IF_ID_inst[15 +: REG_ADDR_WIDTH];
  assign IF_ID_rs2 = IF_ID_inst[20 +: REG_ADDR_WIDTH];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a transaction-level fetch model.
// A latency-randomizing IMEM responder drives gnt/rvalid; every cycle is checked.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        IF_ID_valid;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .pc_imm(pc_imm),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_rs1(IF_ID_rs1),
    .IF_ID_rs2(IF_ID_rs2), .IF_ID_valid(IF_ID_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a queue of fetches still owed by memory, a queue of parked
  // instructions, and the contents of IF/ID.
  typedef struct packed { logic [31:0] pc; logic keep; }       fetch_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } instr_t;

  fetch_t      pend[$];
  instr_t      parked[$];
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;

  // IMEM responder state
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_data;
  logic        rv_real;
  logic        fixed_data;
  logic [31:0] salt;

  int p_stall, p_sel, p_gnt, max_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_data ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ salt);
  endfunction

  task automatic model_reset();
    pend.delete();
    parked.delete();
    m_pc       = RST_PC;
    m_id_pc    = '0;
    m_id_inst  = NOP;
    m_id_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_id_pc    = '0;
    m_id_inst  = NOP;
    m_id_valid = 1'b0;
  endtask

  task automatic model_step(input logic exp_req);
    logic   redir;
    logic   have;
    instr_t item;
    fetch_t f;
    if (reset) begin
      model_reset();
      return;
    end
    redir = pc_sel && !stall;
    have  = 1'b0;
    item  = '0;
    if (pend.size() != 0 && imem_rvalid) begin
      if (!redir && pend[0].keep) begin
        item = '{pc: pend[0].pc, inst: imem_rdata};
        have = 1'b1;
      end
      void'(pend.pop_front());
    end else if (pend.size() != 0 && redir) begin
      f = pend[0];
      f.keep = 1'b0;
      pend[0] = f;
    end
    if (redir) begin
      m_pc = pc_imm;
      parked.delete();
      model_bubble();
    end else begin
      if (exp_req && imem_gnt) begin
        pend.push_back('{pc: m_pc, keep: 1'b1});
        m_pc = m_pc + 32'd4;
      end
      if (stall) begin
        if (have) parked.push_back(item);
      end else if (parked.size() != 0) begin
        item = parked.pop_front();
        m_id_pc = item.pc; m_id_inst = item.inst; m_id_valid = 1'b1;
      end else if (have) begin
        m_id_pc = item.pc; m_id_inst = item.inst; m_id_valid = 1'b1;
      end else begin
        model_bubble();
      end
    end
  endtask

  task automatic run_cycle(input logic do_reset);
    logic exp_req;
    logic [31:0] mi;
    #1;
    reset   = do_reset;
    rv_real = mem_busy && (mem_cnt == 0);
    imem_rvalid = rv_real || (!mem_busy && ($urandom_range(0, 99) < 5));
    imem_rdata  = rv_real ? mem_data : $urandom;
    imem_gnt    = !mem_busy && ($urandom_range(0, 99) < p_gnt);
    stall       = ($urandom_range(0, 99) < p_stall);
    pc_sel      = ($urandom_range(0, 99) < p_sel);
    pc_imm      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);

    @(negedge clk);
    exp_req = !reset && pend.size() == 0 && parked.size() == 0 && !stall && !pc_sel;
    mi = m_id_inst;
    chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (exp_req) chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
    chk("if_id_valid", {63'd0, IF_ID_valid}, {63'd0, m_id_valid});
    chk("if_id_pc", {32'd0, IF_ID_pc}, {32'd0, m_id_pc});
    chk("if_id_inst", {32'd0, IF_ID_inst}, {32'd0, m_id_inst});
    chk("if_id_rs1", {59'd0, IF_ID_rs1}, {59'd0, mi[19:15]});
    chk("if_id_rs2", {59'd0, IF_ID_rs2}, {59'd0, mi[24:20]});

    if (rv_real) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (imem_req && imem_gnt) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(0, max_lat);
      mem_data = mem_word(imem_addr);
    end

    model_step(exp_req);
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; pc_imm = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_data = '0; rv_real = 1'b0;
    fixed_data = 1'b1; salt = '0;
    p_stall = 0; p_sel = 0; p_gnt = 100; max_lat = 0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: begin p_stall = 0;  p_sel = 0;  p_gnt = 100; max_lat = 0; end
        1: begin p_stall = 35; p_sel = 0;  p_gnt = 100; max_lat = 1; end
        2: begin p_stall = 0;  p_sel = 15; p_gnt = 100; max_lat = 2; end
        3: begin p_stall = 30; p_sel = 15; p_gnt = 60;  max_lat = 2; end
        4: begin p_stall = 10; p_sel = 5;  p_gnt = 15;  max_lat = 3; end
        default: begin p_stall = 25; p_sel = 10; p_gnt = 70; max_lat = 4; end
      endcase
      fixed_data = (ph == 0);
      salt = $urandom;
      for (int c = 0; c < 400; c++) begin
        run_cycle((ph != 0 && c == 0) || ($urandom_range(0, 299) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
